// File: rtl/peripheral_bus_pkg.sv
// Shared state encoding and constants for the peripheral bus bridge.
// The optional ACCESS timeout is enabled by defining PERIPHERAL_BUS_TIMEOUT_EN.
package peripheral_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_t;

    localparam logic [31:0] DEFAULT_ERROR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/peripheral_bus_decoder.sv
// Combinational address decoder: maps an address onto one of NUM_SLAVES
// equally sized windows starting at BASE_ADDRESS.
module peripheral_bus_decoder #(
    parameter int                    NUM_SLAVES   = 4,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = ADDR_WIDTH'(32'h00001000),
    parameter int                    REGION_BITS  = 8,
    parameter int                    IDX_W        = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index
);

    localparam logic [ADDR_WIDTH-1:0] SLAVE_COUNT = ADDR_WIDTH'(NUM_SLAVES);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] region;

    // Addresses below the base wrap to a huge offset, so the lower-bound test stays explicit.
    always_comb begin
        offset = addr - BASE_ADDRESS;
        region = offset >> REGION_BITS;
        hit    = (addr >= BASE_ADDRESS) && (region < SLAVE_COUNT);
        index  = region[IDX_W-1:0];
    end

endmodule

// File: rtl/peripheral_bus.sv
// Single-master to multi-slave bus bridge with one-hot slave strobes.
// Define PERIPHERAL_BUS_TIMEOUT_EN to abort silent slave accesses after TIMEOUT_CYCLES.
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = ADDR_WIDTH'(32'h00001000),
    parameter int                    REGION_BITS    = 8,
    parameter int                    TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(DEFAULT_ERROR_DATA)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             master_read,
    input  logic                             master_write,
    input  logic [ADDR_WIDTH-1:0]            master_addr,
    input  logic [DATA_WIDTH-1:0]            master_write_data,
    output logic [DATA_WIDTH-1:0]            master_read_data,
    output logic                             master_response,
    output logic                             bus_error,
    output logic [NUM_SLAVES-1:0]            slave_read,
    output logic [NUM_SLAVES-1:0]            slave_write,
    output logic [ADDR_WIDTH-1:0]            slave_addr,
    output logic [DATA_WIDTH-1:0]            slave_write_data,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_read_data,
    input  logic [NUM_SLAVES-1:0]            slave_response
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_t              state, state_d;
    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_index;
    logic [IDX_W-1:0]        sel_q;
    logic                    wr_q;
    logic                    err_q;
    logic                    accept;
    logic                    load_rdata;
    logic                    err_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [NUM_SLAVES-1:0]   sel_onehot;

    peripheral_bus_decoder #(
        .NUM_SLAVES   (NUM_SLAVES),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .BASE_ADDRESS (BASE_ADDRESS),
        .REGION_BITS  (REGION_BITS),
        .IDX_W        (IDX_W)
    ) u_decoder (
        .addr  (master_addr),
        .hit   (dec_hit),
        .index (dec_index)
    );

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != ST_ACCESS) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        sel_data   = slave_read_data[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
        sel_onehot = NUM_SLAVES'(1) << sel_q;
    end

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        load_rdata = 1'b0;
        err_d      = 1'b0;
        rdata_d    = '0;
        case (state)
            ST_IDLE: begin
                if (master_read || master_write) begin
                    accept = 1'b1;
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d    = ST_RESP;
                        load_rdata = 1'b1;
                        err_d      = 1'b1;
                        rdata_d    = ERROR_DATA;
                    end
                end
            end
            ST_ACCESS: begin
                if (slave_response[sel_q]) begin
                    state_d    = ST_RESP;
                    load_rdata = 1'b1;
                    rdata_d    = wr_q ? '0 : sel_data;
                end
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_d    = ST_RESP;
                    load_rdata = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = ERROR_DATA;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Master must drop both strobes before another request can start.
                if (!master_read && !master_write) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            slave_addr       <= '0;
            slave_write_data <= '0;
            wr_q             <= 1'b0;
            sel_q            <= '0;
            err_q            <= 1'b0;
            master_read_data <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                slave_addr       <= master_addr;
                slave_write_data <= master_write_data;
                wr_q             <= master_write;
                sel_q            <= dec_index;
            end
            if (load_rdata) begin
                master_read_data <= rdata_d;
                err_q            <= err_d;
            end
        end
    end

    always_comb begin
        slave_read      = (state == ST_ACCESS && !wr_q) ? sel_onehot : '0;
        slave_write     = (state == ST_ACCESS &&  wr_q) ? sel_onehot : '0;
        master_response = (state == ST_RESP);
        bus_error       = (state == ST_RESP) && err_q;
    end

endmodule

// File: tb/tb_peripheral_bus.sv
// Self-checking bench for peripheral_bus: directed cases plus randomized
// accesses checked against an address-window reference model.
module tb_peripheral_bus;

    localparam int          NS   = 4;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam int          RB   = 8;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h00001000;
    localparam logic [31:0] ERR  = 32'hDEADBEEF;

    logic             clk = 1'b0;
    logic             reset;
    logic             master_read;
    logic             master_write;
    logic [AW-1:0]    master_addr;
    logic [DW-1:0]    master_write_data;
    logic [DW-1:0]    master_read_data;
    logic             master_response;
    logic             bus_error;
    logic [NS-1:0]    slave_read;
    logic [NS-1:0]    slave_write;
    logic [AW-1:0]    slave_addr;
    logic [DW-1:0]    slave_write_data;
    logic [NS*DW-1:0] slave_read_data;
    logic [NS-1:0]    slave_response;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    peripheral_bus #(
        .NUM_SLAVES     (NS),
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .BASE_ADDRESS   (BASE),
        .REGION_BITS    (RB),
        .TIMEOUT_CYCLES (TMO),
        .ERROR_DATA     (ERR)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .master_read       (master_read),
        .master_write      (master_write),
        .master_addr       (master_addr),
        .master_write_data (master_write_data),
        .master_read_data  (master_read_data),
        .master_response   (master_response),
        .bus_error         (bus_error),
        .slave_read        (slave_read),
        .slave_write       (slave_write),
        .slave_addr        (slave_addr),
        .slave_write_data  (slave_write_data),
        .slave_read_data   (slave_read_data),
        .slave_response    (slave_response)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window index of an address, or -1 when it falls outside every window.
    function automatic int ref_decode(input logic [31:0] a);
        longint unsigned av   = 64'(a);
        longint unsigned lo   = 64'(BASE);
        longint unsigned span = 64'(1) << RB;
        if (av >= lo && av < lo + span * NS) return int'((av - lo) / span);
        return -1;
    endfunction

    // Called at a negedge with the bus idle; returns at a negedge with the bus idle again.
    task automatic run_access(input logic wr, input logic both, input logic [31:0] a,
                              input logic [31:0] wd, input int delay, input int hold,
                              input logic [31:0] sd);
        int          idx     = ref_decode(a);
        logic        is_wr   = wr | both;
        logic [3:0]  hot     = 4'b0;
        logic [3:0]  noise;
        logic [31:0] exp_data;
        master_write      = is_wr;
        master_read       = !wr | both;
        master_addr       = a;
        master_write_data = wd;
        @(negedge clk);
        if (idx < 0) begin
            exp_data = ERR;
            chk("miss_response", master_response, 1);
            chk("miss_bus_error", bus_error, 1);
            chk("miss_rdata", master_read_data, ERR);
            chk("miss_no_strobe", {slave_write, slave_read}, 0);
        end else begin
            hot = 4'b1 << idx;
            chk("slave_addr", slave_addr, a);
            if (is_wr) chk("slave_wdata", slave_write_data, wd);
            for (int k = 0; k <= delay; k++) begin
                chk("strobe", {slave_write, slave_read}, is_wr ? {hot, 4'b0} : {4'b0, hot});
                chk("access_no_resp", master_response, 0);
                chk("rdata_held", master_read_data, last_rdata);
                noise = 4'($urandom) & ~hot;
                slave_response = (k == delay) ? (hot | noise) : noise;
                for (int s = 0; s < NS; s++) slave_read_data[s*DW +: DW] = $urandom;
                slave_read_data[idx*DW +: DW] = sd;
                @(negedge clk);
            end
            slave_response = '0;
            exp_data = is_wr ? 32'h0 : sd;
            chk("hit_response", master_response, 1);
            chk("hit_bus_error", bus_error, 0);
            chk("hit_rdata", master_read_data, exp_data);
            chk("resp_no_strobe", {slave_write, slave_read}, 0);
        end
        last_rdata = exp_data;
        for (int k = 0; k < hold; k++) begin
            master_addr = BASE + 32'($urandom_range(0, 1023));
            slave_response = 4'($urandom);
            @(negedge clk);
            chk("release_quiet", {master_response, slave_write, slave_read}, 0);
        end
        slave_response = '0;
        master_read    = 1'b0;
        master_write   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_quiet", {master_response, slave_write, slave_read}, 0);
        end
        chk("idle_rdata_held", master_read_data, last_rdata);
    endtask

    initial begin
        int          sel;
        int          cnt;
        logic [31:0] a;
        reset             = 1'b1;
        master_read       = 1'b0;
        master_write      = 1'b0;
        master_addr       = '0;
        master_write_data = '0;
        slave_read_data   = '0;
        slave_response    = '0;
        last_rdata        = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_response", {master_response, bus_error}, 0);
        chk("rst_strobes", {slave_write, slave_read}, 0);
        chk("rst_slave_addr", slave_addr, 0);
        chk("rst_slave_wdata", slave_write_data, 0);
        chk("rst_rdata", master_read_data, 0);
        reset = 1'b0;
        @(negedge clk);

        run_access(1'b0, 1'b0, 32'h00001104, 32'h0, 1, 0, 32'h12345678);
        run_access(1'b1, 1'b0, 32'h00001000, 32'hA5, 1, 0, 32'h5555AAAA);
        run_access(1'b0, 1'b0, 32'h00002000, 32'h0, 0, 0, 32'h0);
        run_access(1'b0, 1'b0, 32'h000012FC, 32'h0, 0, 3, 32'hCAFEF00D);
        run_access(1'b1, 1'b1, 32'h000013FC, 32'h77, 2, 1, 32'h11112222);
        run_access(1'b0, 1'b0, 32'h00000FFF, 32'h0, 0, 2, 32'h0);
        run_access(1'b0, 1'b0, 32'h00001400, 32'h0, 0, 0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            if (sel != 3) begin
                a = BASE + 32'($urandom_range(0, NS - 1) << RB) + 32'($urandom_range(0, 255));
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = BASE - 32'd1 - 32'($urandom_range(0, 4095));
                    1:       a = BASE + 32'h400 + 32'($urandom_range(0, 65535));
                    default: a = 32'hFFFF0000 | 32'($urandom);
                endcase
            end
            run_access(1'($urandom), 1'($urandom_range(0, 3) == 0), a, $urandom,
                       $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
        end

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
        master_read = 1'b1;
        master_addr = 32'h00001200;
        cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 50; k++) begin
            if (slave_read != 4'b0100) break;
            cnt++;
            @(negedge clk);
        end
        chk("tmo_access_cycles", cnt, TMO);
        chk("tmo_response", master_response, 1);
        chk("tmo_bus_error", bus_error, 1);
        chk("tmo_rdata", master_read_data, ERR);
        master_read = 1'b0;
        repeat (2) @(negedge clk);
        last_rdata = ERR;
`else
        run_access(1'b0, 1'b0, 32'h00001200, 32'h0, 20, 0, 32'h0BADF00D);
`endif

        master_read = 1'b1;
        master_addr = 32'h00001310;
        @(negedge clk);
        chk("pre_reset_strobe", slave_read, 4'b1000);
        #2 reset = 1'b1;
        master_read = 1'b0;
        #1;
        chk("midrst_strobes", {slave_write, slave_read}, 0);
        chk("midrst_response", {master_response, bus_error}, 0);
        chk("midrst_slave_addr", slave_addr, 0);
        chk("midrst_rdata", master_read_data, 0);
        @(negedge clk);
        reset = 1'b0;
        slave_response = 4'b1000;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {master_response, bus_error, slave_write, slave_read}, 0);
        end
        slave_response = '0;
        last_rdata = 32'h0;
        run_access(1'b0, 1'b0, 32'h00001008, 32'h0, 0, 0, 32'h600DCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
